// File: rtl/trigger_burst_ctrl_pkg.sv
// Shared types and constants for the trigger burst sequencer.
// Holds the FSM state encoding, the default counter width and the config flag bit positions.
package trigger_burst_ctrl_pkg;

    localparam int COUNT_WIDTH_DEF = 32;

    // Position of the enable flag in config flags register 0.
    localparam int FLAG_ENABLE_BIT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/trigger_burst_ctrl_if.sv
// Control, config and status bundle between the register block, the sequencer and the pulse generator.
// start and stop are single-cycle request strobes with no handshake; done and aborted are single-cycle status strobes.
interface trigger_burst_ctrl_if
    import trigger_burst_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) ();

    logic                   enable;
    logic                   start;
    logic                   stop;
    logic [COUNT_WIDTH-1:0] cfg_pulses;
    logic [COUNT_WIDTH-1:0] cfg_gap;
    logic [COUNT_WIDTH-1:0] cfg_bursts;
    logic                   trig_in;
    logic                   gen_run;
    logic                   busy;
    logic                   done;
    logic                   aborted;
    logic [COUNT_WIDTH-1:0] pulse_cnt;
    logic [COUNT_WIDTH-1:0] burst_cnt;

    modport master (
        output enable, start, stop, cfg_pulses, cfg_gap, cfg_bursts, trig_in,
        input  gen_run, busy, done, aborted, pulse_cnt, burst_cnt
    );

    modport slave (
        input  enable, start, stop, cfg_pulses, cfg_gap, cfg_bursts, trig_in,
        output gen_run, busy, done, aborted, pulse_cnt, burst_cnt
    );

endinterface

// File: rtl/trigger_burst_ctrl_edge_detect.sv
// Registered rise/fall detector for a single generator output.
// Edges are reported combinationally in the cycle the new level is first seen.
module trigger_burst_ctrl_edge_detect (
    input  logic clk,
    input  logic resetn,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_sig_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sig_q <= 1'b0;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_q;
    assign o_fall = ~i_sig & r_sig_q;

endmodule

// File: rtl/trigger_burst_ctrl.sv
// Burst sequencer: gates a free-running pulse generator into N-pulse bursts separated by idle gaps.
// Config is shadowed on the accepted start; pulses are counted on falling edges of trig_in.
module trigger_burst_ctrl
    import trigger_burst_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    trigger_burst_ctrl_if.slave  bus,
    output state_e               o_dbg_state
);

    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    state_e                 r_state;
    logic                   r_gen_run;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_aborted;
    logic [COUNT_WIDTH-1:0] r_pulse_cnt;
    logic [COUNT_WIDTH-1:0] r_burst_cnt;
    logic [COUNT_WIDTH-1:0] r_gap_cnt;
    logic [COUNT_WIDTH-1:0] r_sh_pulses;
    logic [COUNT_WIDTH-1:0] r_sh_gap;
    logic [COUNT_WIDTH-1:0] r_sh_bursts;

    logic                   w_trig_fall;
    logic                   w_unused_trig_rise;
    logic                   w_start_ok;
    logic                   w_last_pulse;
    logic                   w_last_burst;
    logic [COUNT_WIDTH-1:0] w_pulse_next;
    logic [COUNT_WIDTH-1:0] w_burst_next;
    logic [COUNT_WIDTH-1:0] w_gap_load;

    trigger_burst_ctrl_edge_detect u_trig_edge (
        .clk    (clk),
        .resetn (resetn),
        .i_sig  (bus.trig_in),
        .o_rise (w_unused_trig_rise),
        .o_fall (w_trig_fall)
    );

    assign w_start_ok   = bus.start & bus.enable & ~bus.stop & (bus.cfg_pulses != '0);
    assign w_pulse_next = r_pulse_cnt + ONE;
    assign w_burst_next = r_burst_cnt + ONE;
    assign w_last_pulse = (w_pulse_next == r_sh_pulses);
    assign w_last_burst = (r_sh_bursts != '0) && (w_burst_next == r_sh_bursts);
    // A zero gap still drops gen_run for one cycle so the generator re-phases.
    assign w_gap_load   = (r_sh_gap == '0) ? ONE : r_sh_gap;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_gen_run   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_pulse_cnt <= '0;
            r_burst_cnt <= '0;
            r_gap_cnt   <= '0;
            r_sh_pulses <= '0;
            r_sh_gap    <= '0;
            r_sh_bursts <= '0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_sh_pulses <= bus.cfg_pulses;
                        r_sh_gap    <= bus.cfg_gap;
                        r_sh_bursts <= bus.cfg_bursts;
                        r_pulse_cnt <= '0;
                        r_burst_cnt <= '0;
                        r_gen_run   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= BURST;
                    end
                end
                BURST: begin
                    if (bus.stop) begin
                        r_state   <= IDLE;
                        r_gen_run <= 1'b0;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (w_trig_fall && r_gen_run) begin
                        r_pulse_cnt <= w_pulse_next;
                        if (w_last_pulse) begin
                            r_burst_cnt <= w_burst_next;
                            r_gen_run   <= 1'b0;
                            if (w_last_burst) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state   <= GAP;
                                r_gap_cnt <= w_gap_load;
                            end
                        end
                    end
                end
                GAP: begin
                    if (bus.stop) begin
                        r_state   <= IDLE;
                        r_gen_run <= 1'b0;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (r_gap_cnt == ONE) begin
                        r_state     <= BURST;
                        r_gen_run   <= 1'b1;
                        r_pulse_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - ONE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_gen_run <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gen_run   = r_gen_run;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.aborted   = r_aborted;
    assign bus.pulse_cnt = r_pulse_cnt;
    assign bus.burst_cnt = r_burst_cnt;
    assign o_dbg_state   = r_state;

endmodule

// File: doc/trigger_burst_ctrl.md
Name: trigger_burst_ctrl

Overview:
- Sequencer that gates a free-running pulse generator (period/width set elsewhere) into bursts: N pulses per burst, a programmable idle gap, then M bursts or unlimited bursts.
- Sits between the config registers and the pulse generator's run input.
- Counts completed pulses from the generator's output and reports progress, done and abort status to software.

Parameters:
- COUNT_WIDTH, 32, width of all count/config fields and status counters.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- enable  in  1  config flag; while 0, start is ignored (does not affect a running sequence).
- start  in  1  single-cycle request to begin a sequence.
- stop  in  1  single-cycle abort request.
- cfg_pulses  in  COUNT_WIDTH  pulses per burst; 0 = invalid, start ignored.
- cfg_gap  in  COUNT_WIDTH  idle cycles between bursts (gen_run low).
- cfg_bursts  in  COUNT_WIDTH  number of bursts; 0 = unlimited.
- trig_in  in  1  pulse generator output, observed.
- gen_run  out  1  run gate to the pulse generator. The generator restarts its phase whenever gen_run rises.
- busy  out  1  high in any state but IDLE.
- done  out  1  one-cycle strobe when the final burst completes.
- aborted  out  1  one-cycle strobe when stop terminates an active sequence.
- pulse_cnt  out  COUNT_WIDTH  completed pulses in current burst.
- burst_cnt  out  COUNT_WIDTH  completed bursts in current sequence.

Behaviour:
- Reset (resetn=0 at clk edge): state=IDLE. gen_run, busy, done and aborted are 0. pulse_cnt and burst_cnt are 0. The trig_in delay register is 0.
- Edge detect: trig_q is trig_in registered. A pulse completes on a falling edge: trig_q=1 and trig_in=0.
- Config shadowing: cfg_pulses, cfg_gap and cfg_bursts are latched on the accepted start. Changes during a sequence have no effect.
- States: IDLE, BURST, GAP.
- IDLE:
  - If start=1, enable=1, cfg_pulses!=0 and stop=0, latch config, clear both counters, and go to BURST.
  - gen_run and busy rise the cycle after start (1-cycle latency).
- BURST:
  - gen_run=1.
  - Each completed pulse increments pulse_cnt.
  - On the completion that makes pulse_cnt equal to shadow pulses:
    - gen_run drops the next cycle.
    - burst_cnt increments.
    - pulse_cnt holds the final value until the next burst starts.
  - After that completion, if shadow bursts!=0 and the new burst_cnt equals shadow bursts:
    - go to IDLE.
    - done=1 for exactly one cycle, coincident with busy falling.
    - The counters hold their final values.
  - Otherwise go to GAP and load the gap counter with max(shadow gap,1).
- GAP:
  - gen_run=0.
  - The gap counter decrements each cycle. When it reaches 1, go to BURST and clear pulse_cnt.
  - gen_run is therefore low for exactly max(gap,1) cycles between bursts.
- stop=1 in BURST or GAP:
  - Go to IDLE next cycle with gen_run=0 and aborted=1 for one cycle.
  - No done strobe. The counters hold.
  - stop has priority over a simultaneous pulse completion or gap expiry.
- stop in IDLE has no effect. start while busy is ignored.
- trig_in edges while gen_run=0 are ignored. This covers a trailing fall of the last pulse, which is already counted on that fall.
- Unlimited mode (shadow bursts=0): burst_cnt wraps modulo 2^COUNT_WIDTH, and the sequence never sets done.
- Counters are COUNT_WIDTH unsigned. The comparisons use equality against the shadow values only.

Decomposition:
- Shared package holds:
  - the state encoding enum {IDLE, BURST, GAP};
  - the default COUNT_WIDTH constant;
  - a flag bit-index constant for enable, bit 0 of flags register 0.
- One natural sub-module: edge_detect, a registered rise/fall detector reusable for other generator outputs.
- The rest is a single FSM plus counters.

Test Plan:
- Finite sequence: pulses=3, gap=5, bursts=2, bench models the generator with period 10 and width 2 -> 3 falling edges per burst. gen_run is low exactly 5 cycles between bursts. done pulses once. Final pulse_cnt=3 and burst_cnt=2. busy falls with done.
- Zero gap: gap=0, pulses=1, bursts=3 -> gen_run is low exactly 1 cycle between bursts. done after the 3rd pulse completes.
- Gating: start with enable=0 or cfg_pulses=0 -> busy stays 0 and gen_run stays 0. start while busy -> no restart and counters are unaffected.
- Abort: stop asserted after 2 of 4 pulses -> gen_run=0 and aborted=1 next cycle. No done. pulse_cnt holds 2. stop in the same cycle as the 4th completion -> aborted, not done.
- Unlimited: bursts=0, pulses=2, run for 10 bursts -> burst_cnt=10 and done never asserted. Then stop -> aborted.
- Reset mid-GAP and mid-BURST: resetn=0 for 1 cycle -> all outputs are 0 next cycle. A subsequent start behaves as in the first scenario. Changing cfg_* mid-sequence does not alter the burst length.
